// File: rtl/phi_rft_digest_core.sv
// 8-point phi-RFT magnitude engine: one bin per cycle, magnitudes folded into a
// 256-bit golden-ratio lattice digest, fixed CORE_LATENCY from accept to result.
module phi_rft_digest_core #(
  parameter int SAMPLE_WIDTH_P  = 16,
  parameter int BLOCK_SAMPLES_P = 8,
  parameter int DIGEST_WIDTH_P  = 256,
  parameter int CORE_LATENCY    = 12
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [SAMPLE_WIDTH_P*BLOCK_SAMPLES_P-1:0] samples,
  input  logic [3:0]                                mode,
  output logic                                      busy,
  output logic                                      digest_valid,
  output logic [DIGEST_WIDTH_P-1:0]                 digest,
  output logic                                      resonance_flag
);
  localparam int NB    = BLOCK_SAMPLES_P;
  localparam int SW    = SAMPLE_WIDTH_P;
  localparam int CNT_W = $clog2(CORE_LATENCY);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CORE_LATENCY - 1);
  localparam logic [CNT_W-1:0] BINS_CNT = CNT_W'(NB);
  localparam logic [31:0]      PHI_W    = 32'h9E3779B9;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  phi_q;
  logic                  busy_q, valid_q, res_q;
  logic [DIGEST_WIDTH_P-1:0] digest_q;
  logic [31:0]           acc_q [NB];
  logic [31:0]           acc_d [NB];
  logic [SW*NB-1:0]      smp_q;
  logic [20:0]           mag_q [NB];

  logic [2:0]            bin_k;
  logic                  proc_bin;
  logic [20:0]           mag_k;
  logic                  res_d;

  // Reserved mode bits are deliberately dropped.
  logic unused_mode;
  assign unused_mode = ^mode[3:1];

  assign bin_k    = cnt_q[2:0];
  assign proc_bin = (state_q == RUN) && (cnt_q < BINS_CNT);

  // Q1.15 cosine table; sine is the same table rotated by six entries.
  function automatic logic signed [15:0] cos_rom(input logic [2:0] m);
    case (m)
      3'd0:    cos_rom = 16'sh7FFF;
      3'd1:    cos_rom = 16'sh5A82;
      3'd2:    cos_rom = 16'sh0000;
      3'd3:    cos_rom = 16'shA57E;
      3'd4:    cos_rom = 16'sh8001;
      3'd5:    cos_rom = 16'shA57E;
      3'd6:    cos_rom = 16'sh0000;
      default: cos_rom = 16'sh5A82;
    endcase
  endfunction

  always_comb begin
    logic signed [34:0] re_sum, im_sum, im_neg;
    logic signed [31:0] prod_c, prod_s;
    logic signed [15:0] x;
    logic signed [19:0] re_k, im_k;
    logic [19:0]        re_abs, im_abs;
    logic [2:0]         m;
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path leaves it unassigned, which would infer a latch.
    re_sum = '0;
    im_sum = '0;
    for (int n = 0; n < NB; n++) begin
      m      = bin_k * 3'(n);
      x      = signed'(smp_q[SW*n +: SW]);
      prod_c = x * cos_rom(m);
      prod_s = x * cos_rom(m + 3'd6);
      re_sum = re_sum + 35'(prod_c);
      im_sum = im_sum + 35'(prod_s);
    end
    im_neg = -im_sum;
    re_k   = 20'(re_sum >>> 15);
    im_k   = 20'(im_neg >>> 15);
    re_abs = re_k[19] ? -re_k : re_k;
    im_abs = im_k[19] ? -im_k : im_k;
    mag_k  = {1'b0, re_abs} + {1'b0, im_abs};
  end

  // Every digest word absorbs the current bin in parallel.
  always_comb begin
    logic [31:0] w;
    for (int j = 0; j < NB; j++) begin
      w = 32'(8*j + 1) + 32'(bin_k);
      if (phi_q) w = w * PHI_W;
      acc_d[j] = acc_q[j] + w * {11'd0, mag_k};
    end
  end

  // A bin dominates when twice its magnitude exceeds the total of all bins.
  always_comb begin
    logic [23:0] mag_sum;
    mag_sum = '0;
    res_d   = 1'b0;
    for (int k = 0; k < NB; k++) mag_sum = mag_sum + 24'(mag_q[k]);
    for (int k = 0; k < NB; k++)
      if (25'({mag_q[k], 1'b0}) > {1'b0, mag_sum}) res_d = 1'b1;
  end

  // NOTE: captured samples and magnitudes carry no reset; each block rewrites
  // them before they are read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) smp_q <= samples;
    if (proc_bin) mag_q[bin_k] <= mag_k;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phi_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= 1'b0;
      digest_q <= '0;
      for (int j = 0; j < NB; j++) acc_q[j] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            phi_q   <= mode[0];
            for (int j = 0; j < NB; j++) acc_q[j] <= '0;
          end
        end
        default: begin
          cnt_q <= cnt_q + 1'b1;
          if (proc_bin) acc_q <= acc_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            res_q   <= res_d;
            for (int j = 0; j < NB; j++) digest_q[32*j +: 32] <= acc_q[j];
          end
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign digest_valid   = valid_q;
  assign digest         = digest_q;
  assign resonance_flag = res_q;

endmodule

// File: tb/tb_phi_rft_digest_core.sv
// Directed bench for phi_rft_digest_core: hand-derived bin magnitudes, digest
// folded by a small weight model, latency/throughput and reset-abort checks.
module tb_phi_rft_digest_core;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] samples = '0;
  logic [3:0]   mode = '0;
  logic         busy, digest_valid, resonance_flag;
  logic [255:0] digest;

  int total = 0;
  int bad   = 0;

  typedef int unsigned mag_t [8];

  always #5 clk = ~clk;

  phi_rft_digest_core #(
    .SAMPLE_WIDTH_P (16),
    .BLOCK_SAMPLES_P(8),
    .DIGEST_WIDTH_P (256),
    .CORE_LATENCY   (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .samples       (samples),
    .mode          (mode),
    .busy          (busy),
    .digest_valid  (digest_valid),
    .digest        (digest),
    .resonance_flag(resonance_flag)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_digest(input mag_t m, input bit phi);
    logic [255:0] d;
    logic [31:0]  w, acc;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        w = 32'(8*j + k + 1);
        if (phi) w = w * 32'h9E3779B9;
        acc = acc + w * 32'(m[k]);
      end
      d[32*j +: 32] = acc;
    end
    return d;
  endfunction

  function automatic logic [127:0] make_alt(input logic [15:0] ev, input logic [15:0] od);
    logic [127:0] b;
    for (int n = 0; n < 8; n++) b[16*n +: 16] = (n % 2 == 1) ? od : ev;
    return b;
  endfunction

  // Accepts one block, scrambles the inputs right after acceptance, then
  // checks latency, busy shape, result, and that the pulse lasts one cycle.
  task automatic run_block(input string tag, input logic [127:0] blk, input logic [3:0] md,
                           input logic [255:0] exp_d, input logic exp_res);
    int lat;
    int early;
    @(negedge clk);
    samples = blk;
    mode    = md;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    samples = ~blk;
    mode    = ~md;
    check({tag, "_busy_accept"}, busy, 1);
    lat   = 0;
    early = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (digest_valid) lat = i;
      else if (!busy) early++;
    end
    check({tag, "_latency"}, lat, 12);
    check({tag, "_busy_at_valid"}, busy, 0);
    check({tag, "_busy_gap"}, early, 0);
    check({tag, "_digest"}, digest, exp_d);
    check({tag, "_res"}, resonance_flag, exp_res);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, digest_valid, 0);
    check({tag, "_digest_hold"}, digest, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    mag_t         m;
    logic [127:0] dc_blk, imp_blk;
    logic [255:0] e;
    int           pulses, wrong_t, nv, bz;

    dc_blk  = {8{16'h28BA}};
    imp_blk = {112'd0, 16'h7333};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_res", resonance_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    m = '{83405, 0, 0, 0, 0, 0, 0, 0};
    run_block("dc", dc_blk, 4'h1, exp_digest(m, 1'b1), 1'b1);
    check("dc_d0", digest[31:0], 32'h1FF45625);

    m = '{29490, 29490, 29490, 29490, 29490, 29490, 29490, 29490};
    run_block("impulse", imp_blk, 4'h0, exp_digest(m, 1'b0), 1'b0);

    m = '{0, 0, 0, 0, 83405, 0, 0, 0};
    run_block("alt", make_alt(16'h28BA, 16'hD746), 4'hF, exp_digest(m, 1'b1), 1'b1);

    m = '{83406, 0, 0, 0, 0, 0, 0, 0};
    run_block("negdc", {8{16'hD746}}, 4'h0, exp_digest(m, 1'b0), 1'b1);

    run_block("zeros", 128'd0, 4'h1, 256'd0, 1'b0);

    // Start held high throughout: pulses must land every 13 cycles.
    m       = '{83405, 0, 0, 0, 0, 0, 0, 0};
    e       = exp_digest(m, 1'b1);
    pulses  = 0;
    wrong_t = 0;
    @(negedge clk);
    samples = dc_blk;
    mode    = 4'h1;
    start   = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      if (digest_valid) begin
        check($sformatf("b2b_digest%0d", pulses), digest, e);
        if (c != 12 + 13 * pulses) wrong_t++;
        pulses++;
        if (pulses == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 4);
    check("b2b_spacing", wrong_t, 0);

    // Abort an in-flight impulse block with a 5-cycle reset.
    nv = 0;
    bz = 0;
    @(negedge clk);
    samples = imp_blk;
    mode    = 4'h0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      nv += int'(digest_valid);
    end
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      nv += int'(digest_valid);
      bz += int'(busy);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      nv += int'(digest_valid);
      bz += int'(busy);
    end
    check("abort_valid", nv, 0);
    check("abort_busy", bz, 0);
    check("abort_digest", digest, 0);
    check("abort_res", resonance_flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
